pmul_sequencer: RTL and testbench

Multi-cycle controller for the packed SIMD multiply ops (smul16/umul16/smul8/umul8) of the 4-stage core. It shares one 17x17 signed multiplier across the lanes and computes one lane per cycle. It stalls the pipeline while busy and returns a 64-bit packed product for writeback to the register pair. It sits in execute beside the ALU and is started by the decoded alu_control code.

---
 rtl/pmul_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pmul_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pmul_sequencer.sv
// pmul_sequencer
// Multi-cycle controller for the packed SIMD multiplies (smul16/umul16/smul8/umul8).
// One shared MUL_W x MUL_W signed multiplier handles one lane per cycle. The
// sequencer stalls the pipeline while it works and returns a 64-bit packed
// product for writeback to a register pair.
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   start        execute-stage op valid, only looked at in IDLE
//   alu_control  op code; 111xx is a packed multiply, bit1 = 8-bit lanes, bit0 = unsigned
//   src_a/src_b  packed operands
//   flush        synchronous abort (e.g. taken-branch flush)
//   stall_o      hold IF/ID/EX registers
//   busy         sequencer not idle
//   done         one-cycle pulse, result valid
//   result       packed products
module pmul_sequencer #(
    parameter int XLEN  = 32,
    parameter int MUL_W = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4:0]          alu_control,
    input  logic [XLEN-1:0]     src_a,
    input  logic [XLEN-1:0]     src_b,
    input  logic                flush,
    output logic                stall_o,
    output logic                busy,
    output logic                done,
    output logic [2*XLEN-1:0]   result
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             lane, lane_nxt;
    logic [XLEN-1:0]        op_a, op_b;
    logic                   mode_8, mode_u;
    logic                   accept, load, wr;
    logic [1:0]             last_lane;
    logic [15:0]            raw_a, raw_b;
    logic signed [MUL_W-1:0] ext_a, ext_b;
    logic signed [XLEN-1:0] prod;

    // Widen a lane to the multiplier width; 8-bit lanes use only v[7:0].
    function automatic logic signed [MUL_W-1:0] ext_lane(input logic [15:0] v,
                                                         input logic m8,
                                                         input logic u);
        logic signed [MUL_W-1:0] r;
        if (m8)
            r = u ? {{(MUL_W-8){1'b0}}, v[7:0]}  : {{(MUL_W-8){v[7]}},  v[7:0]};
        else
            r = u ? {{(MUL_W-16){1'b0}}, v[15:0]} : {{(MUL_W-16){v[15]}}, v[15:0]};
        return r;
    endfunction

    // Only the low 2*lane_width bits are ever kept, so an XLEN-wide product suffices.
    function automatic logic signed [XLEN-1:0] mul_lo(input logic signed [MUL_W-1:0] x,
                                                      input logic signed [MUL_W-1:0] y);
        logic signed [XLEN-1:0] xw, yw;
        xw = XLEN'(x);
        yw = XLEN'(y);
        return xw * yw;
    endfunction

    assign accept    = (state == IDLE) && start && (alu_control[4:2] == 3'b111);
    assign last_lane = mode_8 ? 2'd3 : 2'd1;

    // Lane extraction by shifting the latched operand down to bit 0.
    always_comb begin
        raw_a = 16'h0;
        raw_b = 16'h0;
        if (mode_8) begin
            raw_a = {8'h0, 8'(op_a >> {lane, 3'b000})};
            raw_b = {8'h0, 8'(op_b >> {lane, 3'b000})};
        end else begin
            raw_a = 16'(op_a >> {lane[0], 4'b0000});
            raw_b = 16'(op_b >> {lane[0], 4'b0000});
        end
    end

    assign ext_a = ext_lane(raw_a, mode_8, mode_u);
    assign ext_b = ext_lane(raw_b, mode_8, mode_u);
    assign prod  = mul_lo(ext_a, ext_b);

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        load      = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    lane_nxt  = 2'd0;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                wr = 1'b1;
                if (lane == last_lane) begin
                    lane_nxt  = 2'd0;
                    state_nxt = DONE;
                end else begin
                    lane_nxt = lane + 2'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything, including an accept in the same cycle.
        if (flush) begin
            state_nxt = IDLE;
            lane_nxt  = 2'd0;
            load      = 1'b0;
            wr        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lane   <= 2'd0;
            op_a   <= '0;
            op_b   <= '0;
            mode_8 <= 1'b0;
            mode_u <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            lane  <= lane_nxt;
            if (load) begin
                op_a   <= src_a;
                op_b   <= src_b;
                mode_8 <= alu_control[1];
                mode_u <= alu_control[0];
                result <= '0;
            end else if (wr) begin
                if (mode_8) begin
                    case (lane)
                        2'd0:    result[15:0]  <= prod[15:0];
                        2'd1:    result[31:16] <= prod[15:0];
                        2'd2:    result[47:32] <= prod[15:0];
                        default: result[63:48] <= prod[15:0];
                    endcase
                end else if (lane[0]) begin
                    result[63:32] <= prod;
                end else begin
                    result[31:0]  <= prod;
                end
            end
        end
    end

    // stall_o follows the raw accept condition even when a flush cancels it.
    assign stall_o = accept || (state == MUL);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_pmul_sequencer.sv
module tb_pmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stall_o, busy, done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    pmul_sequencer #(.XLEN(32), .MUL_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stall_o(stall_o), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; alu_control = 5'd0;
        src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        #12;
        checks++;
        if ({stall_o, busy, done} !== 3'b000 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset: stall/busy/done=%b result=%h expected 000 / 0",
                     {stall_o, busy, done}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one op and check stall/busy/done per cycle plus the final result.
    task automatic test_op(input string name, input logic [4:0] code,
                           input logic [31:0] a, input logic [31:0] b,
                           input int n, input logic [63:0] exp);
        @(negedge clk);
        start = 1'b1; alu_control = code; src_a = a; src_b = b;
        #1;
        checks++;
        if ({stall_o, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL %s accept cycle: stall/busy/done=%b expected 100", name, {stall_o, busy, done});
        end
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            checks++;
            if ({stall_o, busy, done} !== 3'b110) begin
                errors++;
                $display("FAIL %s mul cycle k+%0d: stall/busy/done=%b expected 110", name, c, {stall_o, busy, done});
            end
            @(negedge clk);
        end
        checks++;
        if ({stall_o, busy, done} !== 3'b011 || result !== exp) begin
            errors++;
            $display("FAIL %s done cycle: stall/busy/done=%b result=%h expected 011 / %h",
                     name, {stall_o, busy, done}, result, exp);
        end
        @(negedge clk);
        checks++;
        if ({stall_o, busy, done} !== 3'b000 || result !== exp) begin
            errors++;
            $display("FAIL %s hold: stall/busy/done=%b result=%h expected 000 / %h",
                     name, {stall_o, busy, done}, result, exp);
        end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        start = 1'b1; alu_control = 5'b01010; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({stall_o, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL ignore cycle %0d: stall/busy/done=%b expected 000", c, {stall_o, busy, done});
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // start held high: accepts at offsets 0 and 4, done at 3 and 7.
    task automatic test_back_to_back();
        logic [2:0] exp;
        @(negedge clk);
        start = 1'b1; alu_control = 5'b11100; src_a = 32'hFFFF_0003; src_b = 32'h0002_FFFE;
        for (int off = 0; off < 8; off++) begin
            #1;
            exp[2] = (off != 3) && (off != 7);
            exp[1] = (off != 0) && (off != 4);
            exp[0] = (off == 3) || (off == 7);
            checks++;
            if ({stall_o, busy, done} !== exp) begin
                errors++;
                $display("FAIL b2b offset %0d: stall/busy/done=%b expected %b", off, {stall_o, busy, done}, exp);
            end
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result !== 64'hFFFF_FFFE_FFFF_FFFA) begin
            errors++;
            $display("FAIL b2b end: busy=%b result=%h expected 0 / fffffffefffffffa", busy, result);
        end
    endtask

    task automatic test_flush();
        // flush in cycle k+2 of smul8
        @(negedge clk);
        start = 1'b1; alu_control = 5'b11110; src_a = 32'h807F_FF02; src_b = 32'h807F_02FF;
        @(negedge clk); start = 1'b0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int c = 3; c < 7; c++) begin
            #1;
            checks++;
            if ({stall_o, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL flush mid-mul k+%0d: stall/busy/done=%b expected 000", c, {stall_o, busy, done});
            end
            @(negedge clk);
        end
        // flush together with an accept: stall follows accept, nothing latched
        start = 1'b1; flush = 1'b1; alu_control = 5'b11100;
        #1;
        checks++;
        if ({stall_o, busy} !== 2'b10) begin
            errors++;
            $display("FAIL flush+accept: stall/busy=%b expected 10", {stall_o, busy});
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if ({stall_o, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL flush+accept next: stall/busy/done=%b expected 000", {stall_o, busy, done});
        end
        // flush in the DONE cycle: done still pulses
        @(negedge clk);
        start = 1'b1; alu_control = 5'b11101; src_a = 32'hFFFF_0003; src_b = 32'h0002_FFFE;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || result !== 64'h0001_FFFE_0002_FFFA) begin
            errors++;
            $display("FAIL flush in done: done=%b result=%h expected 1 / 0001fffe0002fffa", done, result);
        end
        @(negedge clk); flush = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL flush after done: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; alu_control = 5'b11100; src_a = 32'hFFFF_0003; src_b = 32'h0002_FFFE;
        @(negedge clk); start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_o, busy, done} !== 3'b000 || result !== 64'd0) begin
            errors++;
            $display("FAIL async reset: stall/busy/done=%b result=%h expected 000 / 0",
                     {stall_o, busy, done}, result);
        end
        @(negedge clk); rst_n = 1'b1;
        test_op("smul8 after reset", 5'b11110, 32'h807F_FF02, 32'h807F_02FF, 4, 64'h4000_3F01_FFFE_FFFE);
    endtask

    initial begin
        test_reset();
        test_op("smul16", 5'b11100, 32'hFFFF_0003, 32'h0002_FFFE, 2, 64'hFFFF_FFFE_FFFF_FFFA);
        test_op("umul16", 5'b11101, 32'hFFFF_0003, 32'h0002_FFFE, 2, 64'h0001_FFFE_0002_FFFA);
        test_op("smul8",  5'b11110, 32'h807F_FF02, 32'h807F_02FF, 4, 64'h4000_3F01_FFFE_FFFE);
        test_op("umul8",  5'b11111, 32'h807F_FF02, 32'h807F_02FF, 4, 64'h4000_3F01_01FE_01FE);
        test_ignore();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
